mix_scheduler: RTL and testbench
================================

Name: mix_scheduler

Overview:
- Sequences waveform summation for the synth output stage through one shared adder, visiting one source per clock cycle.
- Sits between the waveform generators (square, saw, tri, sine, memory playback) and the audio output path.
- On each sample tick it snapshots all sources, accumulates the enabled ones, and publishes one saturated sample plus a valid strobe.

Parameters:
- NUM_SRC, 5, number of source channels; index NUM_SRC-1 is the memory-playback channel.
- W, 16, sample width in bits (unsigned).
- SAT, 1, 1 = clamp the final sum to 2^W-1; 0 = keep the low W bits (wrap).

Ports:
- clk  input  1  system clock (1 MHz)
- rst  input  1  reset; the asynchronous, active-high reset
- sample_tick  input  1  one-cycle pulse that requests a new output sample
- gate  input  1  note gate (button); enables the generator channels
- src_en  input  NUM_SRC  per-channel enable (from switches)
- src_data  input  NUM_SRC*W  packed sources; channel i occupies bits [i*W +: W]
- sig  output  W  mixed output sample
- sig_valid  output  1  one-cycle pulse; sig updated this cycle
- busy  output  1  high while not IDLE
- overrun  output  1  sticky; set when sample_tick arrives while busy

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; sig=0, sig_valid=0, busy=0, overrun=0.
  - Accumulator, index and snapshot registers are all 0.
- States: IDLE -> ACCUM -> DONE -> IDLE.
- IDLE, sample_tick=1 (cycle T0):
  - Latch src_data into the snapshot registers.
  - Latch the effective mask: for i < NUM_SRC-1, mask[i] = src_en[i] & gate; mask[NUM_SRC-1] = src_en[NUM_SRC-1] (memory channel ignores gate).
  - Clear acc; idx=0; go to ACCUM.
- ACCUM: on each cycle, if mask[idx], add snap[idx] to acc, then increment idx.
  - acc width is W + clog2(NUM_SRC) bits, so it never overflows.
  - After idx = NUM_SRC-1 is processed, go to DONE.
- DONE: sig = (SAT && acc > 2^W-1) ? 2^W-1 : acc[W-1:0]. Assert sig_valid for exactly this cycle, then go to IDLE.
- Latency: sig_valid at T0 + NUM_SRC + 1 (cycle 6 for the default). The minimum tick period is NUM_SRC + 2 cycles.
- sig holds its value between updates and is never glitched mid-accumulation.
- busy = (state != IDLE), registered with the state.
- sample_tick in ACCUM or DONE: ignored, no restart; overrun latches to 1 and stays 1 until reset.
- sample_tick in the same cycle as DONE's return to IDLE: ignored and flagged as overrun, since the state is DONE that cycle.
- All masks zero: the sequence still runs and produces sig=0 with a sig_valid pulse.
- Changes to src_data, src_en or gate after T0 do not affect the current sample.
- rst asserted mid-sequence: immediate return to the reset values. No sig_valid is produced for the aborted sample.

Decomposition:
- Shared package synth_pkg holds:
  - the SAMPLE_W = 16 constant;
  - the state encoding typedef mix_state_t {IDLE, ACCUM, DONE};
  - the MEM_CH index constant.
- Optional sub-module sat_clamp: a combinational clamp of the wide accumulator to W bits, parameterised by W and SAT and reused by later mixers. Everything else stays inline.

Test Plan:
- Reset then idle: rst pulse, no ticks -> sig=0, sig_valid=0, busy=0, overrun=0 held for 20 cycles.
- Basic mix: src_en=5'b00011, gate=1, square=1000, saw=2000, mem=500 (mem disabled), tick -> sig=3000 with sig_valid exactly 6 cycles after the tick; busy high for cycles 1..6.
- Gate/memory rule:
  - gate=0, src_en=5'b11111, all sources=100, tick -> sig=100 (memory only).
  - Same stimulus with gate=1 -> sig=500.
- Saturation: SAT=1, src_en=5'b00011, square=0xF000, saw=0x2000 -> sig=0xFFFF. With SAT=0 -> sig=0x1000.
- Overrun and snapshot:
  - Tick, then change src_data to 0 at cycle 2 -> result uses the values from the tick cycle.
  - A second tick at cycle 3 -> ignored, overrun=1 and sticky. The next legal tick still produces a correct sample.
- Reset mid-sequence: tick, assert rst at cycle 3 -> busy=0 and sig=0 immediately, with no sig_valid pulse. A fresh tick after release yields the correct sum.

Source files
------------

// File: rtl/synth_pkg.sv
// Shared constants and types for the synth output stage.
package synth_pkg;

  localparam int unsigned SAMPLE_W    = 16;
  localparam int unsigned DEF_NUM_SRC = 5;
  // Memory-playback channel sits at the top index and ignores the note gate.
  localparam int unsigned MEM_CH      = DEF_NUM_SRC - 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } mix_state_t;

endpackage

// File: rtl/mix_scheduler_if.sv
// Sample-tick request, source bus and mixed-sample result for the mixer.
interface mix_scheduler_if #(
  parameter int unsigned NUM_SRC = synth_pkg::DEF_NUM_SRC,
  parameter int unsigned W       = synth_pkg::SAMPLE_W
);
  logic                 sample_tick;
  logic                 gate;
  logic [NUM_SRC-1:0]   src_en;
  logic [NUM_SRC*W-1:0] src_data;
  logic [W-1:0]         sig;
  logic                 sig_valid;
  logic                 busy;
  logic                 overrun;

  modport master (
    output sample_tick, gate, src_en, src_data,
    input  sig, sig_valid, busy, overrun
  );

  modport slave (
    input  sample_tick, gate, src_en, src_data,
    output sig, sig_valid, busy, overrun
  );
endinterface

// File: rtl/sat_clamp.sv
// Narrows a wide unsigned accumulator to W bits, either clamping at 2^W-1 or wrapping.
module sat_clamp #(
  parameter int unsigned IN_W = 19,
  parameter int unsigned W    = 16,
  parameter bit          SAT  = 1'b1
) (
  input  logic [IN_W-1:0] acc,
  output logic [W-1:0]    sig
);

  always_comb begin
    sig = acc[W-1:0];
    if (SAT && (|acc[IN_W-1:W])) begin
      sig = '1;
    end
  end

endmodule

// File: rtl/mix_scheduler.sv
// Snapshots all sources on a sample tick, sums the enabled ones through one adder
// (one source per cycle) and publishes a clamped or wrapped sample with a valid strobe.
module mix_scheduler import synth_pkg::*; #(
  parameter int unsigned NUM_SRC = DEF_NUM_SRC,
  parameter int unsigned W       = SAMPLE_W,
  parameter bit          SAT     = 1'b1
) (
  input logic            clk,
  input logic            rst,
  mix_scheduler_if.slave bus
);

  localparam int unsigned IdxW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int unsigned AccW = W + $clog2(NUM_SRC);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_SRC - 1);

  mix_state_t         state_q;
  logic [IdxW-1:0]    idx_q;
  logic [AccW-1:0]    acc_q;
  logic [W-1:0]       snap_q [NUM_SRC];
  logic [NUM_SRC-1:0] mask_q;
  logic [W-1:0]       sig_q;
  logic               sig_valid_q;
  logic               busy_q;
  logic               overrun_q;

  logic [NUM_SRC-1:0] mask_d;
  logic [AccW-1:0]    acc_sum;
  logic [W-1:0]       sig_clamped;

  // Generator channels need the gate; the top (memory) channel does not.
  assign mask_d = bus.src_en & {1'b1, {(NUM_SRC-1){bus.gate}}};

  always_comb begin
    acc_sum = acc_q;
    if (mask_q[idx_q]) begin
      acc_sum = acc_q + AccW'(snap_q[idx_q]);
    end
  end

  sat_clamp #(
    .IN_W (AccW),
    .W    (W),
    .SAT  (SAT)
  ) u_sat_clamp (
    .acc (acc_sum),
    .sig (sig_clamped)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      acc_q       <= '0;
      mask_q      <= '0;
      sig_q       <= '0;
      sig_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
      for (int i = 0; i < NUM_SRC; i++) begin
        snap_q[i] <= '0;
      end
    end else begin
      sig_valid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.sample_tick) begin
            for (int i = 0; i < NUM_SRC; i++) begin
              snap_q[i] <= bus.src_data[i*W +: W];
            end
            mask_q  <= mask_d;
            acc_q   <= '0;
            idx_q   <= '0;
            state_q <= ACCUM;
            busy_q  <= 1'b1;
          end
        end
        ACCUM: begin
          if (bus.sample_tick) begin
            overrun_q <= 1'b1;
          end
          acc_q <= acc_sum;
          if (idx_q == LastIdx) begin
            // Outputs are registered, so the result is published on entry to DONE.
            sig_q       <= sig_clamped;
            sig_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            idx_q <= idx_q + IdxW'(1);
          end
        end
        DONE: begin
          if (bus.sample_tick) begin
            overrun_q <= 1'b1;
          end
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.sig       = sig_q;
  assign bus.sig_valid = sig_valid_q;
  assign bus.busy      = busy_q;
  assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_mix_scheduler.sv
// Directed bench for mix_scheduler: a saturating and a wrapping instance share stimulus.
module tb_mix_scheduler;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  mix_scheduler_if #(.NUM_SRC(5), .W(16)) bus_s ();
  mix_scheduler_if #(.NUM_SRC(5), .W(16)) bus_w ();

  assign bus_w.sample_tick = bus_s.sample_tick;
  assign bus_w.gate        = bus_s.gate;
  assign bus_w.src_en      = bus_s.src_en;
  assign bus_w.src_data    = bus_s.src_data;

  mix_scheduler #(.NUM_SRC(5), .W(16), .SAT(1'b1)) u_dut_sat (
    .clk (clk),
    .rst (rst),
    .bus (bus_s.slave)
  );

  mix_scheduler #(.NUM_SRC(5), .W(16), .SAT(1'b0)) u_dut_wrap (
    .clk (clk),
    .rst (rst),
    .bus (bus_w.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        gate;
    logic [4:0]  en;
    logic [79:0] data;
    logic [15:0] exp_sat;
    logic [15:0] exp_wrap;
  } vec_t;

  function automatic logic [79:0] pack5(input logic [15:0] s0, input logic [15:0] s1,
                                        input logic [15:0] s2, input logic [15:0] s3,
                                        input logic [15:0] s4);
    return {s4, s3, s2, s1, s0};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Issues one tick and returns the cycle count until sig_valid (0 on timeout).
  task automatic run_sample(input logic g, input logic [4:0] en, input logic [79:0] d,
                            output int lat, output logic busy_ok);
    bus_s.gate        = g;
    bus_s.src_en      = en;
    bus_s.src_data    = d;
    bus_s.sample_tick = 1'b1;
    step();
    bus_s.sample_tick = 1'b0;
    lat     = 0;
    busy_ok = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      if (!bus_s.busy) busy_ok = 1'b0;
      if (bus_s.sig_valid) begin
        lat = k;
        break;
      end
      step();
    end
  endtask

  vec_t vecs [8];
  int   lat;
  logic busy_ok;
  logic seen;

  initial begin
    checks   = 0;
    failures = 0;
    rst               = 1'b1;
    bus_s.sample_tick = 1'b0;
    bus_s.gate        = 1'b0;
    bus_s.src_en      = '0;
    bus_s.src_data    = '0;

    vecs[0] = '{1'b1, 5'b00011, pack5(16'd1000, 16'd2000, 16'd0, 16'd0, 16'd500),
                16'd3000, 16'd3000};
    vecs[1] = '{1'b0, 5'b11111, pack5(16'd100, 16'd100, 16'd100, 16'd100, 16'd100),
                16'd100, 16'd100};
    vecs[2] = '{1'b1, 5'b11111, pack5(16'd100, 16'd100, 16'd100, 16'd100, 16'd100),
                16'd500, 16'd500};
    vecs[3] = '{1'b1, 5'b00011, pack5(16'hF000, 16'h2000, 16'd0, 16'd0, 16'd0),
                16'hFFFF, 16'h1000};
    vecs[4] = '{1'b1, 5'b00000, pack5(16'd11, 16'd22, 16'd33, 16'd44, 16'd55),
                16'd0, 16'd0};
    vecs[5] = '{1'b0, 5'b10000, pack5(16'h00FF, 16'h00FF, 16'h00FF, 16'h00FF, 16'hFFFF),
                16'hFFFF, 16'hFFFF};
    vecs[6] = '{1'b1, 5'b11111, pack5(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF),
                16'hFFFF, 16'hFFFB};
    vecs[7] = '{1'b1, 5'b10101, pack5(16'd1, 16'd2, 16'd4, 16'd8, 16'd16),
                16'd21, 16'd21};

    // Reset, then idle with no ticks.
    step();
    step();
    check("rst_sig", 32'(bus_s.sig), 32'd0);
    check("rst_busy", 32'(bus_s.busy), 32'd0);
    rst = 1'b0;
    for (int c = 0; c < 20; c++) begin
      step();
      check("idle_sig", 32'(bus_s.sig), 32'd0);
      check("idle_valid", 32'(bus_s.sig_valid), 32'd0);
      check("idle_busy", 32'(bus_s.busy), 32'd0);
      check("idle_overrun", 32'(bus_s.overrun), 32'd0);
    end

    // Table-driven mixes.
    for (int v = 0; v < 8; v++) begin
      run_sample(vecs[v].gate, vecs[v].en, vecs[v].data, lat, busy_ok);
      check("latency", 32'(lat), 32'd6);
      check("busy_during", 32'(busy_ok), 32'd1);
      check("sig_sat", 32'(bus_s.sig), 32'(vecs[v].exp_sat));
      check("sig_wrap", 32'(bus_w.sig), 32'(vecs[v].exp_wrap));
      check("valid_wrap", 32'(bus_w.sig_valid), 32'd1);
      step();
      check("valid_drop", 32'(bus_s.sig_valid), 32'd0);
      check("busy_drop", 32'(bus_s.busy), 32'd0);
      check("sig_hold", 32'(bus_s.sig), 32'(vecs[v].exp_sat));
    end
    check("no_overrun_yet", 32'(bus_s.overrun), 32'd0);

    // Snapshot isolation plus an overrun tick at cycle 3.
    bus_s.gate        = 1'b1;
    bus_s.src_en      = 5'b00011;
    bus_s.src_data    = pack5(16'd1000, 16'd2000, 16'd0, 16'd0, 16'd500);
    bus_s.sample_tick = 1'b1;
    step();
    bus_s.sample_tick = 1'b0;
    step();
    bus_s.src_data = '0;
    bus_s.src_en   = '0;
    bus_s.gate     = 1'b0;
    step();
    bus_s.sample_tick = 1'b1;
    step();
    bus_s.sample_tick = 1'b0;
    check("overrun_set", 32'(bus_s.overrun), 32'd1);
    check("overrun_busy", 32'(bus_s.busy), 32'd1);
    step();
    check("snap_not_yet", 32'(bus_s.sig_valid), 32'd0);
    step();
    check("snap_valid", 32'(bus_s.sig_valid), 32'd1);
    check("snap_sig", 32'(bus_s.sig), 32'd3000);
    step();
    check("no_restart", 32'(bus_s.busy), 32'd0);
    check("overrun_sticky", 32'(bus_s.overrun), 32'd1);
    run_sample(1'b1, 5'b00100, pack5(16'd0, 16'd0, 16'h0123, 16'd0, 16'd0), lat, busy_ok);
    check("post_ovr_lat", 32'(lat), 32'd6);
    check("post_ovr_sig", 32'(bus_s.sig), 32'h123);
    check("overrun_still", 32'(bus_s.overrun), 32'd1);
    step();

    // Reset mid-sequence aborts the sample.
    bus_s.gate        = 1'b1;
    bus_s.src_en      = 5'b00111;
    bus_s.src_data    = pack5(16'd10, 16'd20, 16'd30, 16'd0, 16'd0);
    bus_s.sample_tick = 1'b1;
    step();
    bus_s.sample_tick = 1'b0;
    step();
    step();
    rst = 1'b1;
    #1;
    check("abort_busy", 32'(bus_s.busy), 32'd0);
    check("abort_sig", 32'(bus_s.sig), 32'd0);
    check("abort_overrun", 32'(bus_s.overrun), 32'd0);
    check("abort_valid", 32'(bus_s.sig_valid), 32'd0);
    step();
    rst  = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      step();
      if (bus_s.sig_valid || bus_s.busy) seen = 1'b1;
    end
    check("abort_quiet", 32'(seen), 32'd0);
    run_sample(1'b1, 5'b00111, pack5(16'd10, 16'd20, 16'd30, 16'd0, 16'd0), lat, busy_ok);
    check("fresh_lat", 32'(lat), 32'd6);
    check("fresh_sig", 32'(bus_s.sig), 32'd60);
    check("fresh_no_ovr", 32'(bus_s.overrun), 32'd0);

    // A tick during DONE is dropped and flagged.
    bus_s.sample_tick = 1'b1;
    step();
    bus_s.sample_tick = 1'b0;
    check("done_tick_busy", 32'(bus_s.busy), 32'd0);
    check("done_tick_ovr", 32'(bus_s.overrun), 32'd1);
    step();
    check("done_tick_idle", 32'(bus_s.busy), 32'd0);
    check("done_tick_sig", 32'(bus_s.sig), 32'd60);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
